open_drain_tx: RTL and testbench
================================

Name: open_drain_tx

Overview:
- Transmitter for a single-wire open-drain (wired-AND) serial line.
- The line idles high through a passive PMOS-style pull-up.
- This block drives only the NMOS pull-down gate (pd_en) and never drives the line high.
- It serializes a parallel word into a framed bit stream, reads the line back to detect contention, and sits between a parallel producer and the shared line.

Parameters:
- BIT_CYCLES, 16, clock cycles per bit period; legal range 2..65535.
- DATA_BITS, 8, payload bits per frame; legal range 1..32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- tx_data  input  DATA_BITS  word to send; sent LSB first.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  block can accept a word this cycle.
- line_in  input  1  sensed line level (1 = high/released, 0 = low).
- pd_en  output  1  pull-down gate drive (1 = pull line low, 0 = release).
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse: frame completed without contention.
- arb_lost  output  1  one-cycle pulse: frame aborted on contention.

Behaviour:
- Reset values: pd_en=0, busy=0, done=0, arb_lost=0, state=IDLE, counters=0. The line is released during reset.
- Reset mid-frame: takes effect on the next edge; pd_en=0 immediately after that edge; no done or arb_lost pulse.
- Registered outputs: pd_en, busy, done and arb_lost are all registered.
- tx_ready is combinational: tx_ready = (state==IDLE) && line_in && !rst.
  - The block does not start a frame while the line is held low by another node.
- Handshake: transfer occurs on an edge where tx_valid && tx_ready. tx_data is captured into a shift register on that edge. tx_data may change afterwards.
- State machine: IDLE, START, DATA, STOP. bit_cnt counts 0..BIT_CYCLES-1; bit_idx counts 0..DATA_BITS-1.
- IDLE -> START on transfer.
  - Next cycle: pd_en=1, busy=1, bit_cnt=0.
- START (pd_en=1) lasts BIT_CYCLES cycles, then -> DATA with bit_idx=0.
- DATA: pd_en = ~shift[0] (0 bit = pull low, 1 bit = release).
  - Each bit lasts BIT_CYCLES cycles.
  - At the end of a bit, shift right and increment bit_idx.
  - After bit DATA_BITS-1, -> STOP.
- STOP (pd_en=0) lasts BIT_CYCLES cycles, then -> IDLE.
  - done=1 for the single cycle following the final STOP cycle; busy=0 in that same cycle.
- Frame length: (DATA_BITS+2)*BIT_CYCLES cycles of busy=1, starting the cycle after transfer.
- Contention check: sampled when bit_cnt == BIT_CYCLES/2 (integer divide) in any DATA or STOP bit where pd_en==0.
  - If line_in==0 at that sample: next edge -> IDLE, pd_en=0, busy=0, arb_lost=1 for one cycle, no done.
  - The remaining bits are discarded.
- No contention check when pd_en==1, including START. Line level is ignored while this node drives low.
- Back-to-back frames: a new transfer is allowed in the done or arb_lost cycle if line_in==1. START then follows immediately, with no idle gap beyond that cycle.
- tx_valid while busy is ignored; tx_ready=0 holds the producer off.
- done and arb_lost are mutually exclusive and never both asserted.

Test Plan:
- Reset, then idle with line_in=1 -> tx_ready=1, pd_en=0, busy=0, done=0, arb_lost=0.
- BIT_CYCLES=4, DATA_BITS=8, send 0xA5; line model line_in = ~pd_en -> pd_en per 4-cycle bit period is 1 (start), then 0,1,0,1,1,0,1,0, then 0 (stop). busy high for exactly 40 cycles; done pulses once in cycle 41 after transfer.
- Hold line_in=0 externally while idle with tx_valid=1 -> tx_ready=0, no frame starts. Release line_in=1 -> transfer, START next cycle.
- Send 0xFF; external node pulls line low during data bit 3 -> arb_lost pulse at bit 3 mid-sample + 1 cycle, pd_en=0, busy=0, no done, tx_ready=1 once line high.
- Assert rst during data bit 5 of a frame -> next cycle pd_en=0, busy=0, state IDLE, no done or arb_lost pulse. The next frame is sent correctly.
- Keep tx_valid=1 continuously with 0x00 then 0x3C -> second frame START begins the cycle after done, tx_valid ignored while busy, both frames bit-exact.

Source files
------------

// File: rtl/open_drain_tx.sv
// open_drain_tx
// Transmitter for a single-wire open-drain (wired-AND) serial line. The line
// idles high through a passive pull-up; this block only ever controls the
// pull-down gate. A parallel word is framed as START (low), DATA_BITS payload
// bits sent LSB first (0 = pull low, 1 = release) and STOP (released). Each
// bit lasts BIT_CYCLES clocks. While the line is released the block reads it
// back mid-bit and abandons the frame if another node is holding it low.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active high
//   tx_data   word to send (LSB first)
//   tx_valid  producer has a word on tx_data
//   tx_ready  block can accept a word this cycle (combinational)
//   line_in   sensed line level (1 = released/high, 0 = low)
//   pd_en     pull-down gate drive (1 = pull low), registered
//   busy      frame in progress, registered
//   done      one-cycle pulse, frame finished cleanly, registered
//   arb_lost  one-cycle pulse, frame aborted on contention, registered
module open_drain_tx #(
   parameter int BIT_CYCLES = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 line_in,
   output logic                 pd_en,
   output logic                 busy,
   output logic                 done,
   output logic                 arb_lost
);

   localparam int CNT_W = 16;
   localparam int IDX_W = 6;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BIT_CYCLES / 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t               state_r,    state_s;
   logic [CNT_W-1:0]     bit_cnt_r,  bit_cnt_s;
   logic [IDX_W-1:0]     bit_idx_r,  bit_idx_s;
   logic [DATA_BITS-1:0] shift_r,    shift_s;
   logic                 pd_en_r,    pd_en_s;
   logic                 busy_r,     busy_s;
   logic                 done_r,     done_s;
   logic                 arb_lost_r, arb_lost_s;

   logic                 tx_ready_s;
   logic                 xfer_s;
   logic                 bit_end_s;
   logic                 contend_s;
   logic [DATA_BITS-1:0] shifted_s;

   // Refuse a new word while another node holds the line low.
   assign tx_ready_s = (state_r == ST_IDLE) && line_in && !rst;
   assign xfer_s     = tx_valid && tx_ready_s;
   assign bit_end_s  = (bit_cnt_r == CNT_LAST);
   assign shifted_s  = shift_r >> 1;
   // Contention only matters while we have released the line; when we pull
   // low ourselves the sensed level says nothing about other nodes.
   assign contend_s  = ((state_r == ST_DATA) || (state_r == ST_STOP)) &&
                       (bit_cnt_r == CNT_MID) && !pd_en_r && !line_in;

   assign tx_ready = tx_ready_s;
   assign pd_en    = pd_en_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign arb_lost = arb_lost_r;

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_s    = state_r;
      bit_cnt_s  = bit_cnt_r;
      bit_idx_s  = bit_idx_r;
      shift_s    = shift_r;
      pd_en_s    = pd_en_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      arb_lost_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            pd_en_s   = 1'b0;
            busy_s    = 1'b0;
            bit_cnt_s = {CNT_W{1'b0}};
            bit_idx_s = {IDX_W{1'b0}};
            if (xfer_s) begin
               state_s = ST_START;
               shift_s = tx_data;
               pd_en_s = 1'b1;
               busy_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_START: begin
            if (bit_end_s) begin
               state_s   = ST_DATA;
               bit_cnt_s = {CNT_W{1'b0}};
               bit_idx_s = {IDX_W{1'b0}};
               pd_en_s   = ~shift_r[0];
            end else begin
               bit_cnt_s = bit_cnt_r + 16'd1;
            end
         end

         ST_DATA: begin
            if (contend_s) begin
               state_s    = ST_IDLE;
               bit_cnt_s  = {CNT_W{1'b0}};
               bit_idx_s  = {IDX_W{1'b0}};
               pd_en_s    = 1'b0;
               busy_s     = 1'b0;
               arb_lost_s = 1'b1;
            end else if (bit_end_s) begin
               bit_cnt_s = {CNT_W{1'b0}};
               if (bit_idx_r == IDX_LAST) begin
                  state_s = ST_STOP;
                  pd_en_s = 1'b0;
               end else begin
                  shift_s   = shifted_s;
                  bit_idx_s = bit_idx_r + 6'd1;
                  pd_en_s   = ~shifted_s[0];
               end
            end else begin
               bit_cnt_s = bit_cnt_r + 16'd1;
            end
         end

         ST_STOP: begin
            if (contend_s) begin
               state_s    = ST_IDLE;
               bit_cnt_s  = {CNT_W{1'b0}};
               bit_idx_s  = {IDX_W{1'b0}};
               pd_en_s    = 1'b0;
               busy_s     = 1'b0;
               arb_lost_s = 1'b1;
            end else if (bit_end_s) begin
               state_s   = ST_IDLE;
               bit_cnt_s = {CNT_W{1'b0}};
               pd_en_s   = 1'b0;
               busy_s    = 1'b0;
               done_s    = 1'b1;
            end else begin
               bit_cnt_s = bit_cnt_r + 16'd1;
            end
         end

         default: begin
            state_s   = ST_IDLE;
            bit_cnt_s = {CNT_W{1'b0}};
            bit_idx_s = {IDX_W{1'b0}};
            pd_en_s   = 1'b0;
            busy_s    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset releases the line immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         bit_cnt_r  <= {CNT_W{1'b0}};
         bit_idx_r  <= {IDX_W{1'b0}};
         shift_r    <= {DATA_BITS{1'b0}};
         pd_en_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         arb_lost_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         bit_cnt_r  <= bit_cnt_s;
         bit_idx_r  <= bit_idx_s;
         shift_r    <= shift_s;
         pd_en_r    <= pd_en_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         arb_lost_r <= arb_lost_s;
      end
   end

endmodule

// File: tb/tb_open_drain_tx.sv
// Testbench for open_drain_tx with BIT_CYCLES=4, DATA_BITS=8. The shared line
// is modelled as a wired-AND: low if this node or an external node pulls it.
module tb_open_drain_tx;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       line_in;
   logic       pd_en;
   logic       busy;
   logic       done;
   logic       arb_lost;
   logic       ext_pull;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected pull-down level per bit period: bit k = period k
   // (0 = start, 1..8 = data LSB first, 9 = stop).
   typedef struct {
      logic [7:0] data;
      logic [9:0] exp_pd;
   } vec_t;

   vec_t vecs [3];

   open_drain_tx #(.BIT_CYCLES(4), .DATA_BITS(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .line_in  (line_in),
      .pd_en    (pd_en),
      .busy     (busy),
      .done     (done),
      .arb_lost (arb_lost)
   );

   assign line_in = ~(pd_en | ext_pull);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present a word and wait (bounded) for acceptance; returns right after
   // the transfer edge.
   task automatic start_xfer(input logic [7:0] d);
      int waited;
      tx_data  = d;
      tx_valid = 1'b1;
      waited   = 0;
      #1;
      while (!tx_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!tx_ready) begin
         chk("xfer_timeout", 32'(tx_ready), 32'd1);
      end
      @(posedge clk);
   endtask

   // Check a complete frame cycle by cycle, starting just after the transfer
   // edge. Ends at the negedge of the done cycle.
   task automatic check_frame(input logic [9:0] exp_pd, input logic keep_valid,
                              input logic [7:0] nxt);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         chk($sformatf("pd_en c%0d", c), 32'(pd_en), 32'(exp_pd[(c-1)/4]));
         chk($sformatf("busy c%0d", c), 32'(busy), 32'd1);
         chk($sformatf("done c%0d", c), 32'(done), 32'd0);
         chk($sformatf("arb c%0d", c), 32'(arb_lost), 32'd0);
         chk($sformatf("ready c%0d", c), 32'(tx_ready), 32'd0);
         if (c == 1) begin
            if (keep_valid) tx_data = nxt;
            else tx_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("done pulse", 32'(done), 32'd1);
      chk("busy end", 32'(busy), 32'd0);
      chk("pd_en end", 32'(pd_en), 32'd0);
      chk("arb end", 32'(arb_lost), 32'd0);
      chk("ready end", 32'(tx_ready), 32'd1);
   endtask

   initial begin
      vecs[0] = '{data: 8'hA5, exp_pd: 10'b0010110101};
      vecs[1] = '{data: 8'h01, exp_pd: 10'b0111111101};
      vecs[2] = '{data: 8'h3C, exp_pd: 10'b0110000111};

      rst      = 1'b1;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      ext_pull = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst pd_en", 32'(pd_en), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst arb", 32'(arb_lost), 32'd0);
      chk("rst ready", 32'(tx_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle ready", 32'(tx_ready), 32'd1);
      chk("idle pd_en", 32'(pd_en), 32'd0);
      chk("idle busy", 32'(busy), 32'd0);

      // Table-driven frames
      for (int i = 0; i < 3; i++) begin
         start_xfer(vecs[i].data);
         check_frame(vecs[i].exp_pd, 1'b0, 8'h00);
         @(negedge clk);
         chk($sformatf("post done v%0d", i), 32'(done), 32'd0);
      end

      // Line held low by another node: no frame may start
      ext_pull = 1'b1;
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("held ready %0d", c), 32'(tx_ready), 32'd0);
         chk($sformatf("held busy %0d", c), 32'(busy), 32'd0);
      end
      ext_pull = 1'b0;
      #1;
      chk("released ready", 32'(tx_ready), 32'd1);
      @(posedge clk);
      check_frame(10'b0110000111, 1'b0, 8'h00);

      // Contention during data bit 3 of 0xFF
      @(negedge clk);
      start_xfer(8'hFF);
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         chk($sformatf("arbf busy c%0d", c), 32'(busy), 32'd1);
         chk($sformatf("arbf arb c%0d", c), 32'(arb_lost), 32'd0);
         chk($sformatf("arbf pd c%0d", c), 32'(pd_en), (c <= 4) ? 32'd1 : 32'd0);
         if (c == 1) tx_valid = 1'b0;
         if (c == 17) ext_pull = 1'b1;
      end
      @(negedge clk);
      chk("arb pulse", 32'(arb_lost), 32'd1);
      chk("arb busy", 32'(busy), 32'd0);
      chk("arb pd_en", 32'(pd_en), 32'd0);
      chk("arb done", 32'(done), 32'd0);
      chk("arb ready held", 32'(tx_ready), 32'd0);
      ext_pull = 1'b0;
      #1;
      chk("arb ready free", 32'(tx_ready), 32'd1);
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         chk($sformatf("arb after arb %0d", c), 32'(arb_lost), 32'd0);
         chk($sformatf("arb after done %0d", c), 32'(done), 32'd0);
      end

      // Reset during data bit 5 (cycles 25..28 after transfer)
      start_xfer(8'hA5);
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (c == 1) tx_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("mrst pd_en", 32'(pd_en), 32'd0);
      chk("mrst busy", 32'(busy), 32'd0);
      chk("mrst done", 32'(done), 32'd0);
      chk("mrst arb", 32'(arb_lost), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         chk($sformatf("mrst quiet done %0d", c), 32'(done), 32'd0);
         chk($sformatf("mrst quiet arb %0d", c), 32'(arb_lost), 32'd0);
         chk($sformatf("mrst quiet busy %0d", c), 32'(busy), 32'd0);
      end
      chk("mrst ready", 32'(tx_ready), 32'd1);
      start_xfer(8'h01);
      check_frame(10'b0111111101, 1'b0, 8'h00);

      // Back-to-back with tx_valid held high: 0x00 then 0x3C
      @(negedge clk);
      start_xfer(8'h00);
      check_frame(10'b0111111111, 1'b1, 8'h3C);
      @(posedge clk);
      check_frame(10'b0110000111, 1'b0, 8'h00);
      @(negedge clk);
      chk("b2b idle busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
